// File: rtl/fft_reorder_controller_if.sv
// rtl/fft_reorder_controller_if.sv - sample-in / reordered-out stream bundle for fft_reorder_controller
interface fft_reorder_controller_if #(
   parameter int WIDTH = 2,
   parameter int IDX_W = 2
);
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             out_ready;
   logic             out_last;
   logic [IDX_W-1:0] out_index;
   logic [15:0]      frames_done;

   // Environment side: sample source and downstream sink
   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid, out_last, out_index, frames_done
   );

   // Controller side
   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid, out_last, out_index, frames_done
   );
endinterface

// File: rtl/fft_reorder_controller.sv
// rtl/fft_reorder_controller.sv - frame buffer replayed in bit-reversed order; PING_PONG_EN selects two banks
module fft_reorder_controller #(
   parameter int SAMPLES = 4,
   parameter int WIDTH   = 2
) (
   input logic                    clk,
   input logic                    reset,
   fft_reorder_controller_if.slave bus
);
   localparam int IDX_W = $clog2(SAMPLES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SAMPLES - 1);
`ifdef PING_PONG_EN
   localparam int NB = 2;
`else
   localparam int NB = 1;
`endif
   localparam int AW = $clog2(NB * SAMPLES);

   typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_t;

   bank_state_t      bank_state [NB];
   bank_state_t      wr_state;
   bank_state_t      rd_state;
   logic [IDX_W-1:0] wr_cnt;
   logic [IDX_W-1:0] rd_cnt;
   logic [15:0]      frames_done;
   logic [WIDTH-1:0] mem [NB*SAMPLES];
   logic [AW-1:0]    wr_addr;
   logic [AW-1:0]    rd_addr;
   logic             in_fire;
   logic             out_fire;

   function automatic logic [IDX_W-1:0] bitrev(input logic [IDX_W-1:0] x);
      logic [IDX_W-1:0] r;
      for (int i = 0; i < IDX_W; i++) r[i] = x[IDX_W-1-i];
      return r;
   endfunction

`ifdef PING_PONG_EN
   logic wr_bank;
   logic rd_bank;
   assign wr_state = bank_state[wr_bank];
   assign rd_state = bank_state[rd_bank];
   assign wr_addr  = {wr_bank, wr_cnt};
   assign rd_addr  = {rd_bank, bitrev(rd_cnt)};
`else
   localparam logic wr_bank = 1'b0;
   localparam logic rd_bank = 1'b0;
   assign wr_state = bank_state[0];
   assign rd_state = bank_state[0];
   assign wr_addr  = wr_cnt;
   assign rd_addr  = bitrev(rd_cnt);
`endif

   // The write bank accepts while empty/filling; the read bank offers while full/draining
   assign bus.in_ready    = (wr_state == EMPTY) || (wr_state == FILLING);
   assign bus.out_valid   = (rd_state == FULL)  || (rd_state == DRAINING);
   assign bus.out_data    = mem[rd_addr];
   assign bus.out_index   = rd_cnt;
   assign bus.out_last    = bus.out_valid && (rd_cnt == LAST_IDX);
   assign bus.frames_done = frames_done;

   assign in_fire  = bus.in_valid  && bus.in_ready;
   assign out_fire = bus.out_valid && bus.out_ready;

   // Frame buffer write; contents survive reset, only the bank states are cleared
   always_ff @(posedge clk) begin
      if (in_fire) mem[wr_addr] <= bus.in_data;
   end

   // Per-bank state machines, pointers and the drained-frame counter
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int b = 0; b < NB; b++) bank_state[b] <= EMPTY;
         wr_cnt      <= '0;
         rd_cnt      <= '0;
         frames_done <= '0;
`ifdef PING_PONG_EN
         wr_bank     <= 1'b0;
         rd_bank     <= 1'b0;
`endif
      end else begin
         if (in_fire) begin
            wr_cnt <= (wr_cnt == LAST_IDX) ? '0 : wr_cnt + IDX_W'(1);
         end
         if (out_fire) begin
            rd_cnt <= (rd_cnt == LAST_IDX) ? '0 : rd_cnt + IDX_W'(1);
            if (rd_cnt == LAST_IDX) frames_done <= frames_done + 16'd1;
         end
`ifdef PING_PONG_EN
         if (in_fire && wr_cnt == LAST_IDX)  wr_bank <= ~wr_bank;
         if (out_fire && rd_cnt == LAST_IDX) rd_bank <= ~rd_bank;
`endif
         // Writes only touch the write bank, reads only the read bank; they never
         // act on the same bank in one cycle because its state gates one or the other
         for (int b = 0; b < NB; b++) begin
            case (bank_state[b])
               EMPTY:
                  if (in_fire && b == int'(wr_bank)) bank_state[b] <= FILLING;
               FILLING:
                  if (in_fire && b == int'(wr_bank) && wr_cnt == LAST_IDX)
                     bank_state[b] <= FULL;
               FULL:
                  if (out_fire && b == int'(rd_bank)) bank_state[b] <= DRAINING;
               DRAINING:
                  if (out_fire && b == int'(rd_bank) && rd_cnt == LAST_IDX)
                     bank_state[b] <= EMPTY;
               default:
                  bank_state[b] <= EMPTY;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_fft_reorder_controller.sv
// tb/tb_fft_reorder_controller.sv - randomized and directed checks against a frame-queue reference model
module tb_fft_reorder_controller;
   localparam int S  = 8;
   localparam int W  = 8;
   localparam int IW = $clog2(S);
`ifdef PING_PONG_EN
   localparam int NBANKS = 2;
`else
   localparam int NBANKS = 1;
`endif

   typedef logic [W-1:0] frame_t [S];

   logic clk = 1'b0;
   logic reset = 1'b1;

   fft_reorder_controller_if #(.WIDTH(W), .IDX_W(IW)) bus ();

   fft_reorder_controller #(.SAMPLES(S), .WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          failures = 0;
   frame_t      pend [$];
   frame_t      part;
   int          fill = 0;
   int          out_pos = 0;
   logic [15:0] exp_frames = '0;
   int          out_log [$];
   int          order8 [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int rev(input int i);
      int r = 0;
      int x = i;
      for (int k = 0; k < IW; k++) begin
         r = r * 2 + x % 2;
         x = x / 2;
      end
      return r;
   endfunction

   task automatic model_clear();
      pend.delete();
      fill = 0;
      out_pos = 0;
      exp_frames = '0;
      out_log.delete();
   endtask

   task automatic step(input logic v, input logic [W-1:0] d, input logic r);
      logic exp_in_ready;
      logic exp_out_valid;
      logic in_fire;
      logic out_fire;
      int   pidx;
      pidx = 0;
      @(negedge clk);
      bus.in_valid  = v;
      bus.in_data   = d;
      bus.out_ready = r;
      #1;
      exp_in_ready  = pend.size() < NBANKS;
      exp_out_valid = pend.size() > 0;
      chk("in_ready", 32'(bus.in_ready), 32'(exp_in_ready));
      chk("out_valid", 32'(bus.out_valid), 32'(exp_out_valid));
      chk("frames_done", 32'(bus.frames_done), 32'(exp_frames));
      if (exp_out_valid) begin
         pidx = rev(out_pos);
         chk("out_data", 32'(bus.out_data), 32'(pend[0][pidx]));
         chk("out_index", 32'(bus.out_index), 32'(out_pos));
         chk("out_last", 32'(bus.out_last), 32'(out_pos == S - 1));
      end else begin
         chk("out_last_idle", 32'(bus.out_last), 32'd0);
      end
      out_fire = exp_out_valid && r;
      in_fire  = exp_in_ready && v;
      if (out_fire) begin
         out_log.push_back(int'(pend[0][pidx]));
         out_pos++;
         if (out_pos == S) begin
            void'(pend.pop_front());
            out_pos = 0;
            exp_frames = exp_frames + 16'd1;
         end
      end
      if (in_fire) begin
         part[fill] = d;
         fill++;
         if (fill == S) begin
            pend.push_back(part);
            fill = 0;
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      model_clear();
      #1;
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_last", 32'(bus.out_last), 32'd0);
      chk("rst_out_index", 32'(bus.out_index), 32'd0);
      chk("rst_frames_done", 32'(bus.frames_done), 32'd0);
   endtask

   task automatic check_log(input string tag, input int base);
      chk({tag, "_len"}, 32'(out_log.size()), 32'd8);
      for (int k = 0; k < 8 && k < out_log.size(); k++)
         chk({tag, "_seq"}, 32'(out_log[k]), 32'(base + order8[k]));
      out_log.delete();
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      do_reset();

      // Natural-order frame, sink always ready
      for (int i = 0; i < S; i++) step(1'b1, W'(i), 1'b1);
      for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1);
      check_log("order", 0);

      // Same frame, sink alternating ready/stall
      for (int i = 0; i < S; i++) step(1'b1, W'(i), 1'b1);
      for (int i = 0; i < 20; i++) step(1'b0, '0, (i % 2) == 0);
      check_log("stall", 0);

      // Reset in the middle of a drain, then a fresh frame
      for (int i = 0; i < S; i++) step(1'b1, W'(i), 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
      do_reset();
      for (int i = 0; i < S; i++) step(1'b1, W'(10 + i), 1'b1);
      for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1);
      check_log("post_rst", 10);

      // Input held valid while the single bank drains
      for (int i = 0; i < S; i++) step(1'b1, W'(20 + i), 1'b1);
      for (int i = 0; i < 40 && pend.size() > 0; i++)
`ifdef PING_PONG_EN
         step(1'b0, 8'd99, $urandom_range(0, 1) == 1);
`else
         step(1'b1, 8'd99, $urandom_range(0, 1) == 1);
`endif
      check_log("held_valid", 20);
      do_reset();
      for (int i = 0; i < S; i++) step(1'b1, W'(30 + i), 1'b1);
      for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1);
      check_log("after_hold", 30);

      // Continuous input at full rate
      for (int i = 0; i < 3 * S; i++) step(1'b1, W'(i), 1'b1);
      for (int i = 0; i < 3 * S; i++) step(1'b0, '0, 1'b1);
`ifdef PING_PONG_EN
      chk("cont_len", 32'(out_log.size()), 32'(3 * S));
      for (int k = 0; k < 3 * S && k < out_log.size(); k++)
         chk("cont_seq", 32'(out_log[k]), 32'((k / 8) * 8 + order8[k % 8]));
`endif
      out_log.delete();

      // Randomized traffic on both sides
      for (int i = 0; i < 3000; i++)
         step(($urandom % 4) != 0, W'($urandom), ($urandom % 3) != 0);
      for (int i = 0; i < 40; i++) step(1'b0, '0, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
